// File: rtl/sdram_burst_write_if.sv
// Arbiter handshake, write-FIFO pop and SDRAM command/address/data signals of the burst writer.
interface sdram_burst_write_if;
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned BA_W   = 2;
    localparam int unsigned DQ_W   = 16;
    localparam int unsigned BYTE_W = 8;

    logic              wr_trig;
    logic              wr_en;
    logic              ref_req;
    logic              wr_req;
    logic              flag_wr_end;
    logic [CMD_W-1:0]  wr_cmd;
    logic [ADDR_W-1:0] wr_addr;
    logic [BA_W-1:0]   bank_addr;
    logic [DQ_W-1:0]   wr_data;
    logic              wr_dq_oe;
    logic              wfifo_rd_en;
    logic [BYTE_W-1:0] wfifo_rd_data;

    modport master (
        input  wr_trig, wr_en, ref_req, wfifo_rd_data,
        output wr_req, flag_wr_end, wr_cmd, wr_addr, bank_addr, wr_data, wr_dq_oe, wfifo_rd_en
    );

    modport slave (
        output wr_trig, wr_en, ref_req, wfifo_rd_data,
        input  wr_req, flag_wr_end, wr_cmd, wr_addr, bank_addr, wr_data, wr_dq_oe, wfifo_rd_en
    );
endinterface

// File: rtl/sdram_burst_write.sv
// SDRAM burst-4 writer: fills bank 0 rows 0..LAST_ROW from a show-ahead byte FIFO,
// yielding the bus to refresh between bursts and precharging at every row end.
module sdram_burst_write #(
    parameter logic [12:0] LAST_ROW = 13'd0
) (
    input  logic                 sclk,
    input  logic                 s_rst,
    sdram_burst_write_if.master  bus
);
    localparam int unsigned ROW_W  = 13;
    localparam int unsigned COL_W  = 7;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned DQ_W   = 16;

    localparam logic [CMD_W-1:0] CMD_NOP   = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_ACT   = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_WRITE = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_PRE   = 4'b0010;

    localparam logic [ROW_W-1:0] PRE_ALL_ADDR = 13'h0400;
    localparam logic [CNT_W-1:0] CNT_FIRST    = 2'd0;
    localparam logic [CNT_W-1:0] CNT_LAST     = 2'd3;
    localparam logic [COL_W-1:0] COL_LAST     = 7'd127;

    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        REQ  = 5'b00010,
        ACT  = 5'b00100,
        WR   = 5'b01000,
        PRE  = 5'b10000
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  act_cnt_q, act_cnt_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0]  break_cnt_q, break_cnt_d;
    logic [COL_W-1:0]  col_cnt_q, col_cnt_d;
    logic [ROW_W-1:0]  row_addr_q, row_addr_d;
    logic              done_q, done_d;
    logic              ref_brk_q, ref_brk_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [ROW_W-1:0]  addr_q, addr_d;
    logic [DQ_W-1:0]   data_q, data_d;
    logic              dq_oe_q, dq_oe_d;
    logic              flag_q, flag_d;

    // Next-state, counters and next registered bus values; the 2-bit phase counters wrap to 0 on exit.
    always_comb begin
        state_d     = state_q;
        act_cnt_d   = act_cnt_q;
        burst_cnt_d = burst_cnt_q;
        break_cnt_d = break_cnt_q;
        col_cnt_d   = col_cnt_q;
        row_addr_d  = row_addr_q;
        done_d      = done_q;
        ref_brk_d   = ref_brk_q;
        cmd_d       = CMD_NOP;
        addr_d      = addr_q;
        data_d      = {8'h00, bus.wfifo_rd_data};
        dq_oe_d     = 1'b0;
        flag_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.wr_trig) begin
                    state_d    = REQ;
                    row_addr_d = '0;
                    col_cnt_d  = '0;
                    done_d     = 1'b0;
                    ref_brk_d  = 1'b0;
                end
            end
            REQ: begin
                if (bus.wr_en) begin
                    state_d = ACT;
                end
            end
            ACT: begin
                act_cnt_d = act_cnt_q + CNT_W'(1);
                if (act_cnt_q == CNT_FIRST) begin
                    cmd_d  = CMD_ACT;
                    addr_d = row_addr_q;
                end
                if (act_cnt_q == CNT_LAST) begin
                    state_d = WR;
                end
            end
            WR: begin
                dq_oe_d     = 1'b1;
                burst_cnt_d = burst_cnt_q + CNT_W'(1);
                if (burst_cnt_q == CNT_FIRST) begin
                    cmd_d  = CMD_WRITE;
                    addr_d = {4'b0000, col_cnt_q, 2'b00};
                end
                // Burst end: a started burst always completes before any break is taken.
                if (burst_cnt_q == CNT_LAST) begin
                    col_cnt_d = col_cnt_q + COL_W'(1);
                    if (col_cnt_q == COL_LAST) begin
                        row_addr_d = row_addr_q + ROW_W'(1);
                    end
                    if ((row_addr_q == LAST_ROW) && (col_cnt_q == COL_LAST)) begin
                        done_d  = 1'b1;
                        state_d = PRE;
                    end else if (bus.ref_req) begin
                        ref_brk_d = 1'b1;
                        state_d   = PRE;
                    end else if (col_cnt_q == COL_LAST) begin
                        state_d = PRE;
                    end
                end
            end
            PRE: begin
                break_cnt_d = break_cnt_q + CNT_W'(1);
                if (break_cnt_q == CNT_FIRST) begin
                    cmd_d  = CMD_PRE;
                    addr_d = PRE_ALL_ADDR;
                end
                if (break_cnt_q == CNT_LAST) begin
                    if (done_q) begin
                        state_d = IDLE;
                        flag_d  = 1'b1;
                    end else if (ref_brk_q) begin
                        state_d   = REQ;
                        ref_brk_d = 1'b0;
                        flag_d    = 1'b1;
                    end else begin
                        state_d = ACT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state_q     <= IDLE;
            act_cnt_q   <= '0;
            burst_cnt_q <= '0;
            break_cnt_q <= '0;
            col_cnt_q   <= '0;
            row_addr_q  <= '0;
            done_q      <= 1'b0;
            ref_brk_q   <= 1'b0;
            cmd_q       <= CMD_NOP;
            addr_q      <= '0;
            data_q      <= '0;
            dq_oe_q     <= 1'b0;
            flag_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_cnt_q   <= act_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            break_cnt_q <= break_cnt_d;
            col_cnt_q   <= col_cnt_d;
            row_addr_q  <= row_addr_d;
            done_q      <= done_d;
            ref_brk_q   <= ref_brk_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            dq_oe_q     <= dq_oe_d;
            flag_q      <= flag_d;
        end
    end

    assign bus.wr_req      = (state_q == REQ);
    assign bus.wfifo_rd_en = (state_q == WR);
    assign bus.flag_wr_end = flag_q;
    assign bus.wr_cmd      = cmd_q;
    assign bus.wr_addr     = addr_q;
    assign bus.bank_addr   = 2'b00;
    assign bus.wr_data     = data_q;
    assign bus.wr_dq_oe    = dq_oe_q;
endmodule

// File: doc/sdram_burst_write.md
SDRAM_BURST_WRITE -- requirements
Module: sdram_burst_write

Interface
REQ-001 SHALL have parameter LAST_ROW, default 13'd0, last row written (rows 0..LAST_ROW, bank 0).
REQ-002 SHALL have port sclk, input, 1, single clock; all logic on rising edge.
REQ-003 SHALL have port s_rst, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have port wr_trig, input, 1, start-write pulse.
REQ-005 SHALL have port wr_en, input, 1, arbiter grant.
REQ-006 SHALL have port ref_req, input, 1, refresh pending.
REQ-007 SHALL have port wr_req, output, 1, bus request to arbiter.
REQ-008 SHALL have port flag_wr_end, output, 1, one-cycle bus-release pulse.
REQ-009 SHALL have port wr_cmd, output, 4, {CS_n,RAS_n,CAS_n,WE_n}.
REQ-010 SHALL have port wr_addr, output, 13, SDRAM address bus.
REQ-011 SHALL have port bank_addr, output, 2, constant 2'b00.
REQ-012 SHALL have port wr_data, output, 16, SDRAM DQ drive value.
REQ-013 SHALL have port wr_dq_oe, output, 1, DQ output enable.
REQ-014 SHALL have port wfifo_rd_en, output, 1, show-ahead FIFO pop.
REQ-015 SHALL have port wfifo_rd_data, input, 8, FIFO head byte, valid without read latency.

Function
REQ-016 SHALL implement one-hot states IDLE, REQ, ACT, WR, PRE.
REQ-017 SHALL use encodings NOP=0111, ACT=0011, WRITE=0100, PRE=0010.
REQ-018 SHALL, in IDLE, on wr_trig go to REQ and clear row_addr, col_cnt, done and refresh-break flags; SHALL ignore wr_trig in any other state.
REQ-019 SHALL drive wr_req combinationally as (state==REQ); REQ->ACT when wr_en=1.
REQ-020 SHALL, in ACT, count act_cnt 0..3, issue ACT with wr_addr=row_addr at act_cnt=0, NOP otherwise, and enter WR after act_cnt=3 (4 cycles).
REQ-021 SHALL, in WR, cycle burst_cnt 0..3 and issue WRITE with wr_addr={4'b0,col_cnt,2'b00} at burst_cnt=0, NOP otherwise (burst length 4).
REQ-022 SHALL drive wfifo_rd_en combinationally as (state==WR), one byte per cycle.
REQ-023 SHALL register wr_data={8'h00,wfifo_rd_data} and wr_dq_oe=(state==WR), aligned with wr_cmd so beat 0 coincides with WRITE.
REQ-024 SHALL register wr_cmd and wr_addr; wr_addr holds its last value on NOP cycles.
REQ-025 SHALL increment col_cnt (7-bit) at burst_cnt=3; col_cnt=127 at burst_cnt=3 marks row end, col_cnt wraps to 0 and row_addr increments.
REQ-026 SHALL leave WR only at burst_cnt=3 to PRE, priority: last burst (row_addr==LAST_ROW and col_cnt==127) sets done; else ref_req=1 sets refresh-break; else row end.
REQ-027 SHALL, in PRE, count break_cnt 0..3, issue PRE with wr_addr=13'h0400 (A10 all banks) at break_cnt=0, and decide at break_cnt=3.
REQ-028 SHALL, at break_cnt=3: done -> IDLE; refresh-break -> REQ (clear flag, resume same row_addr/col_cnt); otherwise -> ACT.
REQ-029 SHALL pulse flag_wr_end (registered, 1 cycle) when PRE exits to IDLE or REQ; never on PRE->ACT.
REQ-030 SHALL not abort a started burst for ref_req; ref_req in ACT or PRE is evaluated only at the next burst end.
REQ-031 SHALL assume FIFO never empty during WR; no underflow handling.

Reset
REQ-032 SHALL, with s_rst=1 at a clock edge (including mid-burst), return to IDLE with wr_cmd=NOP, wr_addr=0, wr_data=0, wr_dq_oe=0, wr_req=0, flag_wr_end=0, wfifo_rd_en=0, all counters and flags 0.

Verification
REQ-033 LAST_ROW=0, wr_trig then wr_en after 3 cycles -> ACT row 0, 128 WRITEs at cols 0,4..508, 512 pops, one PRE addr 0x0400, flag_wr_end pulse, IDLE.
REQ-034 FIFO bytes 0x11,0x22,0x33,0x44 -> wr_data 0x0011..0x0044 with wr_dq_oe=1, 0x0011 in same cycle as WRITE col 0.
REQ-035 ref_req raised at burst_cnt=1 of col_cnt=5 -> burst completes, PRE, flag_wr_end pulse, wr_req=1; after wr_en, ACT row 0 and WRITE col 24.
REQ-036 LAST_ROW=1 -> after col 508 row 0: PRE, ACT row 1 with no flag_wr_end/wr_req; finish after row 1 col 508.
REQ-037 s_rst asserted at burst_cnt=2 -> next cycle all outputs at reset values; wr_trig during WR ignored (no address change).
